latch_write_ctrl: RTL and testbench

//  Clocked write-side controller for a bank of transparent latches (enable/d/q, active-low reset).

---
 rtl/latch_write_ctrl.sv | 97 +++++++++
 tb/tb_latch_write_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/latch_write_ctrl.sv
// Write-side sequencer for a transparent-latch bank: registered setup/open/hold of lat_d/lat_en,
// then a one-cycle readback check of lat_q against lat_d.
module latch_write_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_en,
  input  logic [WIDTH-1:0] lat_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state | meaning
  // IDLE  | ready for a write, lat_en low
  // SETUP | lat_d driven, lat_en low (SETUP_CYC cycles)
  // OPEN  | lat_en high (OPEN_CYC cycles)
  // HOLD  | lat_en low, lat_d held (HOLD_CYC cycles)
  // CHECK | done pulse, lat_q compared against lat_d
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] OPEN  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] CHECK = 3'd4;

  localparam int MAX_SO  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int MAX_CYC = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      lat_en <= 1'b0;
      lat_d  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_valid) begin
            lat_d <= wr_data;
            cnt   <= SETUP_LD;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lat_en <= 1'b1;
            cnt    <= OPEN_LD;
            state  <= OPEN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OPEN: begin
          if (cnt == '0) begin
            lat_en <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) state <= CHECK;
          else           cnt   <= cnt - 1'b1;
        end
        CHECK: state <= IDLE;
        default: begin
          state  <= IDLE;
          lat_en <= 1'b0;
        end
      endcase
    end
  end

  // Status decodes straight from state so reset clears them asynchronously.
  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == CHECK);
  assign err      = done && (lat_q != lat_d);

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Directed bench for latch_write_ctrl with a behavioural latch bank on lat_q.
module tb_latch_write_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic [7:0] lat_d;
  logic       lat_en;
  logic [7:0] lat_q;
  logic       busy;
  logic       done;
  logic       err;

  logic       force_zero;
  logic [7:0] q_model;

  int pass_cnt  = 0;
  int total_cnt = 0;

  latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .lat_d    (lat_d),
    .lat_en   (lat_en),
    .lat_q    (lat_q),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural transparent latch bank with active-low reset.
  always @* begin
    if (!rst_n)      q_model = 8'h00;
    else if (lat_en) q_model = lat_d;
  end
  assign lat_q = force_zero ? 8'h00 : q_model;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       f;
    logic       en;
    logic [7:0] ld;
    logic       rdy;
    logic       bsy;
    logic       dn;
    logic       er;
    logic [7:0] q;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic v, input logic [7:0] d, input logic f,
                      input logic en, input logic [7:0] ld, input logic rdy,
                      input logic bsy, input logic dn, input logic er, input logic [7:0] q);
    vec_t t;
    t.v = v; t.d = d; t.f = f; t.en = en; t.ld = ld;
    t.rdy = rdy; t.bsy = bsy; t.dn = dn; t.er = er; t.q = q;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic check_outputs(input string tag, input logic en, input logic [7:0] ld,
                               input logic rdy, input logic bsy, input logic dn, input logic er);
    check({tag, ".lat_en"},   32'(lat_en),   32'(en));
    check({tag, ".lat_d"},    32'(lat_d),    32'(ld));
    check({tag, ".wr_ready"}, 32'(wr_ready), 32'(rdy));
    check({tag, ".busy"},     32'(busy),     32'(bsy));
    check({tag, ".done"},     32'(done),     32'(dn));
    check({tag, ".err"},      32'(err),      32'(er));
  endtask

  initial begin
    int done_cnt;
    int done_cyc;
    logic done_err;

    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; force_zero = 1'b0;

    // Reset state, before any clock edge
    #2;
    check_outputs("reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

    // Single write 0xA5: done in cycle 5
    push(1, 8'hA5, 0,  0, 8'hA5, 0, 1, 0, 0, 8'h00);
    push(0, 8'h00, 0,  1, 8'hA5, 0, 1, 0, 0, 8'hA5);
    push(0, 8'h00, 0,  1, 8'hA5, 0, 1, 0, 0, 8'hA5);
    push(0, 8'h00, 0,  0, 8'hA5, 0, 1, 0, 0, 8'hA5);
    push(0, 8'h00, 0,  0, 8'hA5, 0, 1, 1, 0, 8'hA5);
    push(0, 8'h00, 0,  0, 8'hA5, 1, 0, 0, 0, 8'hA5);
    // wr_valid held high: 0x11 then 0x22, accepts six edges apart
    push(1, 8'h11, 0,  0, 8'h11, 0, 1, 0, 0, 8'hA5);
    push(1, 8'h22, 0,  1, 8'h11, 0, 1, 0, 0, 8'h11);
    push(1, 8'h22, 0,  1, 8'h11, 0, 1, 0, 0, 8'h11);
    push(1, 8'h22, 0,  0, 8'h11, 0, 1, 0, 0, 8'h11);
    push(1, 8'h22, 0,  0, 8'h11, 0, 1, 1, 0, 8'h11);
    push(1, 8'h22, 0,  0, 8'h11, 1, 0, 0, 0, 8'h11);
    push(1, 8'h22, 0,  0, 8'h22, 0, 1, 0, 0, 8'h11);
    push(0, 8'h00, 0,  1, 8'h22, 0, 1, 0, 0, 8'h22);
    push(0, 8'h00, 0,  1, 8'h22, 0, 1, 0, 0, 8'h22);
    push(0, 8'h00, 0,  0, 8'h22, 0, 1, 0, 0, 8'h22);
    push(0, 8'h00, 0,  0, 8'h22, 0, 1, 1, 0, 8'h22);
    push(0, 8'h00, 0,  0, 8'h22, 1, 0, 0, 0, 8'h22);
    // lat_q stuck at 0x00, write 0xFF: err with done, then clear
    push(1, 8'hFF, 1,  0, 8'hFF, 0, 1, 0, 0, 8'h00);
    push(0, 8'h00, 1,  1, 8'hFF, 0, 1, 0, 0, 8'h00);
    push(0, 8'h00, 1,  1, 8'hFF, 0, 1, 0, 0, 8'h00);
    push(0, 8'h00, 1,  0, 8'hFF, 0, 1, 0, 0, 8'h00);
    push(0, 8'h00, 1,  0, 8'hFF, 0, 1, 1, 1, 8'h00);
    push(0, 8'h00, 1,  0, 8'hFF, 1, 0, 0, 0, 8'h00);
    // Toggling wr_valid with 0xEE while busy must be ignored
    push(1, 8'h5A, 0,  0, 8'h5A, 0, 1, 0, 0, 8'hFF);
    push(0, 8'hEE, 0,  1, 8'h5A, 0, 1, 0, 0, 8'h5A);
    push(1, 8'hEE, 0,  1, 8'h5A, 0, 1, 0, 0, 8'h5A);
    push(0, 8'hEE, 0,  0, 8'h5A, 0, 1, 0, 0, 8'h5A);
    push(1, 8'hEE, 0,  0, 8'h5A, 0, 1, 1, 0, 8'h5A);
    push(1, 8'hEE, 0,  0, 8'h5A, 1, 0, 0, 0, 8'h5A);
    push(0, 8'hEE, 0,  0, 8'h5A, 1, 0, 0, 0, 8'h5A);

    for (int i = 0; i < vecs.size(); i++) begin
      wr_valid = vecs[i].v; wr_data = vecs[i].d; force_zero = vecs[i].f;
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].en, vecs[i].ld, vecs[i].rdy,
                    vecs[i].bsy, vecs[i].dn, vecs[i].er);
      check($sformatf("vec%0d.lat_q", i), 32'(lat_q), 32'(vecs[i].q));
    end
    wr_valid = 1'b0; force_zero = 1'b0;

    // Reset pulse while OPEN: lat_en drops without a clock edge
    wr_valid = 1'b1; wr_data = 8'hC3;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(posedge clk); #1;
    check("open_before_reset.lat_en", 32'(lat_en), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_outputs("mid_reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      check($sformatf("after_reset%0d.wr_ready", c), 32'(wr_ready), 32'd1);
    end
    check("after_reset.no_done", 32'(done_cnt), 32'd0);

    // Reissued write 0x3C completes normally
    wr_valid = 1'b1; wr_data = 8'h3C;
    done_cnt = 0; done_cyc = 0; done_err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      wr_valid = 1'b0;
      if (done) begin
        done_cnt++;
        done_cyc = c;
        done_err = err;
      end
    end
    check("reissue.done_count", 32'(done_cnt), 32'd1);
    check("reissue.done_cycle", 32'(done_cyc), 32'd5);
    check("reissue.err", 32'(done_err), 32'd0);
    check("reissue.lat_d", 32'(lat_d), 32'h3C);
    check("reissue.model_q", 32'(q_model), 32'h3C);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
